// File: rtl/video_line_fetch_ctrl.sv
// video_line_fetch_ctrl: ping-pong line buffer fetch scheduler.
// Ports: pixel_clk/rst_n, enable, frame_start/line_start timing pulses,
// mem_req/mem_addr/mem_ack/mem_rvalid burst read port,
// lb_wr_en/lb_wr_bank/lb_wr_addr line buffer writes,
// disp_bank, underrun/underrun_clr, busy.
module video_line_fetch_ctrl #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int BURST_LEN   = 16,
  parameter int ADDR_W      = 24,
  parameter int FB_BASE     = 0,
  parameter int LINE_STRIDE = 640
) (
  input  logic              pixel_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              frame_start,
  input  logic              line_start,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  output logic              lb_wr_en,
  output logic              lb_wr_bank,
  output logic [9:0]        lb_wr_addr,
  output logic              disp_bank,
  output logic              underrun,
  input  logic              underrun_clr,
  output logic              busy
);

  localparam int NB  = H_ACTIVE / BURST_LEN;
  localparam int BIW = (NB > 1) ? $clog2(NB) : 1;
  localparam int BW  = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int YW  = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int AW  = ADDR_W + 32;

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  state_t          state;
  logic [YW-1:0]   y;
  logic [YW-1:0]   pend_line;
  logic            pend_bank;
  logic            pending;
  logic            primed;
  logic [BIW-1:0]  burst_idx;
  logic [BW-1:0]   beat_cnt;

  logic [YW-1:0]   y_eff;
  logic            y_last;
  logic [YW-1:0]   sched_line;
  logic            sched;
  logic            sched_busy;
  logic            burst_end;
  logic            last_burst;
  logic            have_pend;
  logic            start_go;
  logic [YW-1:0]   start_line;
  logic            start_bank;

  function automatic logic [ADDR_W-1:0] line_addr(
    input logic [YW-1:0] ln
  );
    logic [AW-1:0] a;
    a = AW'(FB_BASE) + AW'(ln) * AW'(LINE_STRIDE);
    return a[ADDR_W-1:0];
  endfunction

  assign busy     = (state != IDLE);
  assign lb_wr_en = mem_rvalid && (state == DATA);

  // frame_start clears y before the coinciding line_start uses it
  always_comb begin
    y_eff      = frame_start ? '0 : y;
    y_last     = (y_eff == YW'(V_ACTIVE - 1));
    sched_line = y_last ? '0 : y_eff + YW'(1);
    sched      = line_start && enable && primed;
    sched_busy = sched && (state != IDLE);
    burst_end  = (state == DATA) && mem_rvalid &&
                 (beat_cnt == BW'(BURST_LEN - 1));
    last_burst = (burst_idx == BIW'(NB - 1));
    have_pend  = pending || sched_busy;
  end

  // a line fetch begins from idle or replaces an overrun fetch
  always_comb begin
    start_go   = 1'b0;
    start_line = '0;
    start_bank = 1'b0;
    unique case (1'b1)
      (state == IDLE) && enable && sched: begin
        start_go   = 1'b1;
        start_line = sched_line;
        start_bank = ~y_eff[0];
      end
      (state == IDLE) && enable && !primed: begin
        start_go   = 1'b1;
      end
      burst_end && enable && have_pend: begin
        start_go   = 1'b1;
        start_line = sched ? sched_line : pend_line;
        start_bank = sched ? ~y_eff[0] : pend_bank;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
      lb_wr_bank <= 1'b0;
      lb_wr_addr <= '0;
      disp_bank  <= 1'b0;
      underrun   <= 1'b0;
      pending    <= 1'b0;
      pend_line  <= '0;
      pend_bank  <= 1'b0;
      primed     <= 1'b0;
      y          <= '0;
      burst_idx  <= '0;
      beat_cnt   <= '0;
    end else begin
      if (frame_start)
        y <= '0;
      if (line_start) begin
        disp_bank <= y_eff[0];
        y         <= y_last ? y_eff : y_eff + YW'(1);
      end
      if (sched_busy)
        underrun <= 1'b1;
      else if (underrun_clr)
        underrun <= 1'b0;
      if (sched_busy) begin
        pending   <= 1'b1;
        pend_line <= sched_line;
        pend_bank <= ~y_eff[0];
      end
      unique case (state)
        IDLE: begin
          if (!enable) begin
            primed  <= 1'b0;
            pending <= 1'b0;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= DATA;
          end else if (!enable) begin
            mem_req    <= 1'b0;
            state      <= IDLE;
            primed     <= 1'b0;
            pending    <= 1'b0;
            lb_wr_addr <= '0;
          end
        end
        DATA: begin
          if (mem_rvalid) begin
            lb_wr_addr <= lb_wr_addr + 10'd1;
            beat_cnt   <= beat_cnt + BW'(1);
          end
          if (burst_end) begin
            beat_cnt <= '0;
            if (!enable) begin
              state      <= IDLE;
              primed     <= 1'b0;
              pending    <= 1'b0;
              lb_wr_addr <= '0;
            end else if (have_pend) begin
              state <= REQ;
            end else if (!last_burst) begin
              burst_idx <= burst_idx + BIW'(1);
              mem_addr  <= mem_addr + ADDR_W'(BURST_LEN);
              mem_req   <= 1'b1;
              state     <= REQ;
            end else begin
              state      <= IDLE;
              primed     <= 1'b1;
              lb_wr_addr <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (start_go) begin
        state      <= REQ;
        mem_req    <= 1'b1;
        mem_addr   <= line_addr(start_line);
        lb_wr_bank <= start_bank;
        lb_wr_addr <= '0;
        burst_idx  <= '0;
        beat_cnt   <= '0;
        pending    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_video_line_fetch_ctrl.sv
// tb_video_line_fetch_ctrl: scoreboard bench for video_line_fetch_ctrl.
// Memory responder, monitor and stimulus run as separate processes.
module tb_video_line_fetch_ctrl;

  localparam int H  = 640;
  localparam int V  = 480;
  localparam int BL = 16;
  localparam int AW = 24;
  localparam int FB = 0;
  localparam int LS = 640;
  localparam int NB = H / BL;

  logic          pixel_clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          frame_start;
  logic          line_start;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic          mem_rvalid;
  logic          lb_wr_en;
  logic          lb_wr_bank;
  logic [9:0]    lb_wr_addr;
  logic          disp_bank;
  logic          underrun;
  logic          underrun_clr;
  logic          busy;

  video_line_fetch_ctrl #(
    .H_ACTIVE(H), .V_ACTIVE(V), .BURST_LEN(BL),
    .ADDR_W(AW), .FB_BASE(FB), .LINE_STRIDE(LS)
  ) dut (
    .pixel_clk(pixel_clk), .rst_n(rst_n), .enable(enable),
    .frame_start(frame_start), .line_start(line_start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .lb_wr_en(lb_wr_en),
    .lb_wr_bank(lb_wr_bank), .lb_wr_addr(lb_wr_addr),
    .disp_bank(disp_bank), .underrun(underrun),
    .underrun_clr(underrun_clr), .busy(busy)
  );

  always #5 pixel_clk = ~pixel_clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [AW-1:0] exp_req[$];
  logic [10:0]   exp_wr[$];

  int ack_delay = 0;
  int stall     = 0;
  bit rand_ack  = 0;
  bit ack_hold  = 0;
  bit gap_en    = 0;
  int owed      = 0;
  int wr_seen   = 0;
  int ty        = 0;
  bit m_primed  = 0;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // expected bursts and beats of one line fetch (first nb bursts)
  task automatic push_line(input int line, input bit bank, input int nb);
    for (int b = 0; b < nb; b++) begin
      exp_req.push_back(AW'(FB + line * LS + b * BL));
      for (int p = 0; p < BL; p++)
        exp_wr.push_back({bank, 10'(b * BL + p)});
    end
  endtask

  // memory: optional ack delay, BL beats per accepted request
  initial begin
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    forever begin
      @(negedge pixel_clk);
      mem_ack    = 1'b0;
      mem_rvalid = 1'b0;
      if (owed > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
        mem_rvalid = 1'b1;
        owed--;
      end
      if (mem_req && !ack_hold) begin
        if (stall >= ack_delay) begin
          mem_ack = 1'b1;
          stall   = 0;
          owed   += BL;
          if (rand_ack) ack_delay = $urandom_range(0, 3);
        end else begin
          stall++;
        end
      end else if (!mem_req) begin
        stall = 0;
      end
    end
  end

  // monitor: pops expectations whenever the DUT presents output
  initial begin
    logic          prev_stall;
    logic [AW-1:0] held;
    prev_stall = 1'b0;
    held       = '0;
    forever begin
      @(negedge pixel_clk);
      #2;
      if (mem_req && prev_stall)
        check("req_addr_hold", mem_addr, held);
      prev_stall = mem_req && !mem_ack;
      held       = mem_addr;
      if (mem_req && mem_ack) begin
        if (exp_req.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_req: addr %0d, none expected",
                   mem_addr);
        end else begin
          check("req_addr", mem_addr, exp_req.pop_front());
        end
      end
      if (lb_wr_en) begin
        wr_seen++;
        if (exp_wr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: bank %0d addr %0d, none expected",
                   lb_wr_bank, lb_wr_addr);
        end else begin
          check("lb_write", {lb_wr_bank, lb_wr_addr}, exp_wr.pop_front());
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_idle(input string name, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge pixel_clk);
      #3;
      if (exp_req.size() == 0 && exp_wr.size() == 0 && !busy) break;
    end
    if (i == limit) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: %0d reqs %0d beats outstanding",
               name, exp_req.size(), exp_wr.size());
    end
    repeat (2) @(negedge pixel_clk);
    #3;
    check({name, "_busy"}, busy, 0);
    check({name, "_req"}, mem_req, 0);
  endtask

  // one line_start; a scheduled fetch expects nb bursts of its line
  task automatic pulse_line(input bit fs, input bit clr, input int nb);
    int y0;
    y0 = fs ? 0 : ty;
    @(negedge pixel_clk);
    if (enable && m_primed)
      push_line((y0 == V - 1) ? 0 : y0 + 1, bit'(1 - y0 % 2), nb);
    line_start   = 1'b1;
    frame_start  = fs;
    underrun_clr = clr;
    @(negedge pixel_clk);
    line_start   = 1'b0;
    frame_start  = 1'b0;
    underrun_clr = 1'b0;
    #3;
    check("disp_bank", disp_bank, y0 % 2);
    ty = (y0 == V - 1) ? y0 : y0 + 1;
  endtask

  task automatic prime();
    @(negedge pixel_clk);
    push_line(0, 1'b0, NB);
    enable = 1'b1;
    wait_idle("prime", 3000);
    m_primed = 1'b1;
  endtask

  task automatic clear_underrun();
    @(negedge pixel_clk);
    underrun_clr = 1'b1;
    @(negedge pixel_clk);
    underrun_clr = 1'b0;
    #3;
    check("underrun_clr", underrun, 0);
  endtask

  initial begin
    int base;
    int i;
    rst_n        = 1'b0;
    enable       = 1'b0;
    frame_start  = 1'b0;
    line_start   = 1'b0;
    underrun_clr = 1'b0;
    repeat (3) @(negedge pixel_clk);
    #3;
    check("rst_req", mem_req, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wbank", lb_wr_bank, 0);
    check("rst_waddr", lb_wr_addr, 0);
    check("rst_dbank", disp_bank, 0);
    check("rst_underrun", underrun, 0);
    check("rst_busy", busy, 0);
    @(negedge pixel_clk);
    rst_n = 1'b1;

    prime();

    @(negedge pixel_clk);
    frame_start = 1'b1;
    @(negedge pixel_clk);
    frame_start = 1'b0;
    ty = 0;

    gap_en   = 1'b1;
    rand_ack = 1'b1;
    for (int k = 0; k < 6; k++) begin
      pulse_line(1'b0, 1'b0, NB);
      wait_idle("line", 4000);
      check("steady_underrun", underrun, 0);
    end

    rand_ack  = 1'b0;
    ack_delay = 7;
    pulse_line(1'b0, 1'b0, NB);
    wait_idle("stall", 4000);
    ack_delay = 0;

    @(negedge pixel_clk);
    enable   = 1'b0;
    m_primed = 1'b0;
    repeat (2) @(negedge pixel_clk);
    while (ty < V - 1)
      pulse_line(1'b0, 1'b0, NB);
    prime();
    pulse_line(1'b0, 1'b0, NB);
    wait_idle("wrap", 4000);
    pulse_line(1'b1, 1'b0, NB);
    wait_idle("frame0", 4000);

    ack_hold = 1'b1;
    pulse_line(1'b0, 1'b0, 1);
    repeat (20) @(negedge pixel_clk);
    #3;
    check("underrun_pre", underrun, 0);
    pulse_line(1'b0, 1'b0, NB);
    check("underrun_set", underrun, 1);
    ack_hold = 1'b0;
    wait_idle("underrun", 4000);
    check("underrun_sticky", underrun, 1);
    clear_underrun();

    ack_hold = 1'b1;
    pulse_line(1'b0, 1'b0, 1);
    repeat (10) @(negedge pixel_clk);
    pulse_line(1'b0, 1'b1, NB);
    check("underrun_set_wins", underrun, 1);
    ack_hold = 1'b0;
    wait_idle("underrun2", 4000);
    clear_underrun();

    gap_en = 1'b0;
    base   = wr_seen;
    pulse_line(1'b0, 1'b0, NB);
    for (i = 0; i < 200; i++) begin
      if (wr_seen >= base + 6) break;
      @(negedge pixel_clk);
      #3;
    end
    check("beats_before_reset", wr_seen - base, 6);
    @(negedge pixel_clk);
    rst_n    = 1'b0;
    enable   = 1'b0;
    m_primed = 1'b0;
    exp_req.delete();
    exp_wr.delete();
    #3;
    check("mid_rst_req", mem_req, 0);
    check("mid_rst_addr", mem_addr, 0);
    check("mid_rst_wbank", lb_wr_bank, 0);
    check("mid_rst_waddr", lb_wr_addr, 0);
    check("mid_rst_dbank", disp_bank, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_wr_en", lb_wr_en, 0);
    base = wr_seen;
    repeat (15) @(negedge pixel_clk);
    #3;
    check("no_write_in_reset", wr_seen, base);
    @(negedge pixel_clk);
    rst_n = 1'b1;
    repeat (3) @(negedge pixel_clk);
    #3;
    check("idle_after_reset", busy, 0);
    check("scoreboard_empty", exp_req.size() + exp_wr.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
